// File: rtl/wb_regfile_scoreboard_if.sv
// Write-back, operand-read and issue/scoreboard signals of the per-thread register file.
interface wb_regfile_scoreboard_if #(
    parameter int DATA_WIDTH        = 64,
    parameter int REG_INDEX_BITS    = 5,
    parameter int THREAD_INDEX_BITS = 3
);
    localparam int NT = 1 << THREAD_INDEX_BITS;

    logic                         wb_flag;
    logic [REG_INDEX_BITS-1:0]    wb_reg_index;
    logic [THREAD_INDEX_BITS-1:0] wb_thread_index;
    logic [DATA_WIDTH-1:0]        wb_data;

    logic                         rd_en;
    logic [THREAD_INDEX_BITS-1:0] rd_thread;
    logic [REG_INDEX_BITS-1:0]    rs1_index;
    logic [REG_INDEX_BITS-1:0]    rs2_index;
    logic [DATA_WIDTH-1:0]        rs1_data;
    logic [DATA_WIDTH-1:0]        rs2_data;

    logic                         issue_valid;
    logic [THREAD_INDEX_BITS-1:0] issue_thread;
    logic [REG_INDEX_BITS-1:0]    issue_rd;

    logic                         hazard;
    logic [NT-1:0]                thread_idle;

    modport master (
        output wb_flag, wb_reg_index, wb_thread_index, wb_data,
        output rd_en, rd_thread, rs1_index, rs2_index,
        output issue_valid, issue_thread, issue_rd,
        input  rs1_data, rs2_data, hazard, thread_idle
    );

    modport slave (
        input  wb_flag, wb_reg_index, wb_thread_index, wb_data,
        input  rd_en, rd_thread, rs1_index, rs2_index,
        input  issue_valid, issue_thread, issue_rd,
        output rs1_data, rs2_data, hazard, thread_idle
    );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Multithreaded register file with write-back bypass and a per-register pending scoreboard
// that flags RAW hazards for the decode stage.
module wb_regfile_scoreboard #(
    parameter int DATA_WIDTH        = 64,
    parameter int REG_INDEX_BITS    = 5,
    parameter int THREAD_INDEX_BITS = 3
) (
    input logic                    clk,
    input logic                    reset,
    wb_regfile_scoreboard_if.slave bus
);
    localparam int NT = 1 << THREAD_INDEX_BITS;
    localparam int NR = 1 << REG_INDEX_BITS;

    logic [DATA_WIDTH-1:0]    regs [NT][NR];
    logic [NT-1:0][NR-1:0]    pending;
    logic [NT-1:0][NR-1:0]    pending_next;
    logic [NT-1:0]            idle_next;
    logic [NT-1:0]            idle_q;
    logic [DATA_WIDTH-1:0]    rs1_q;
    logic [DATA_WIDTH-1:0]    rs2_q;
    logic [DATA_WIDTH-1:0]    rs1_next;
    logic [DATA_WIDTH-1:0]    rs2_next;
    logic                     wb_write;
    logic                     wb_same_thread;
    logic                     rs1_pending;
    logic                     rs2_pending;

    assign wb_write       = bus.wb_flag && (bus.wb_reg_index != '0);
    assign wb_same_thread = bus.wb_flag && (bus.wb_thread_index == bus.rd_thread);

    // Storage is deliberately left out of reset; only the write path is blocked during it.
    always_ff @(posedge clk) begin
        if (!reset && wb_write)
            regs[bus.wb_thread_index][bus.wb_reg_index] <= bus.wb_data;
    end

    always_comb begin
        rs1_next = '0;
        rs2_next = '0;
        if (bus.rs1_index != '0)
            rs1_next = (wb_same_thread && bus.wb_reg_index == bus.rs1_index)
                       ? bus.wb_data : regs[bus.rd_thread][bus.rs1_index];
        if (bus.rs2_index != '0)
            rs2_next = (wb_same_thread && bus.wb_reg_index == bus.rs2_index)
                       ? bus.wb_data : regs[bus.rd_thread][bus.rs2_index];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (bus.rd_en) begin
            rs1_q <= rs1_next;
            rs2_q <= rs2_next;
        end
    end

    // Set is applied after clear so a same-cycle issue to a completing register stays pending.
    always_comb begin
        pending_next = pending;
        if (bus.wb_flag)
            pending_next[bus.wb_thread_index][bus.wb_reg_index] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0)
            pending_next[bus.issue_thread][bus.issue_rd] = 1'b1;
        for (int t = 0; t < NT; t++)
            idle_next[t] = ~|pending_next[t];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            idle_q  <= '1;
        end else begin
            pending <= pending_next;
            idle_q  <= idle_next;
        end
    end

    // A register completing this cycle is not a hazard because the bypass delivers it.
    assign rs1_pending = pending[bus.rd_thread][bus.rs1_index]
                         && !(wb_same_thread && bus.wb_reg_index == bus.rs1_index);
    assign rs2_pending = pending[bus.rd_thread][bus.rs2_index]
                         && !(wb_same_thread && bus.wb_reg_index == bus.rs2_index);

    assign bus.hazard      = bus.rd_en && (rs1_pending || rs2_pending);
    assign bus.rs1_data    = rs1_q;
    assign bus.rs2_data    = rs2_q;
    assign bus.thread_idle = idle_q;
endmodule

// File: doc/wb_regfile_scoreboard.md
WB_REGFILE_SCOREBOARD -- requirements
Module: wb_regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, register data width.
REQ-002 SHALL have parameter REG_INDEX_BITS, default 5, architectural register index width (32 regs/thread).
REQ-003 SHALL have parameter THREAD_INDEX_BITS, default 3, hardware thread index width (NT = 2**THREAD_INDEX_BITS = 8 threads).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wb_flag  input  1  write-back request from the MEM2/WB pipeline register.
REQ-007 SHALL have port wb_reg_index  input  REG_INDEX_BITS  write-back destination register.
REQ-008 SHALL have port wb_thread_index  input  THREAD_INDEX_BITS  write-back thread.
REQ-009 SHALL have port wb_data  input  DATA_WIDTH  write-back value.
REQ-010 SHALL have port rd_en  input  1  operand read request from decode.
REQ-011 SHALL have port rd_thread  input  THREAD_INDEX_BITS  thread for reads and hazard check.
REQ-012 SHALL have ports rs1_index, rs2_index  input  REG_INDEX_BITS each  source registers.
REQ-013 SHALL have ports rs1_data, rs2_data  output  DATA_WIDTH each  registered operand values.
REQ-014 SHALL have port issue_valid  input  1  instruction issuing with a destination register this cycle.
REQ-015 SHALL have ports issue_thread  input  THREAD_INDEX_BITS and issue_rd  input  REG_INDEX_BITS  thread and destination of the issuing instruction.
REQ-016 SHALL have port hazard  output  1  combinational: a source of rd_thread is pending.
REQ-017 SHALL have port thread_idle  output  NT  bit t high when thread t has no pending registers (registered).

Function
REQ-018 SHALL hold storage of NT x 32 x DATA_WIDTH, one register set per thread.
REQ-019 SHALL write wb_data into [wb_thread_index][wb_reg_index] at the clock edge when wb_flag=1 and wb_reg_index!=0.
REQ-020 SHALL ignore writes to register 0; register 0 SHALL read as 0 in every thread.
REQ-021 SHALL have 1-cycle read latency: when rd_en=1 at edge N, rs1_data/rs2_data SHALL present the values from edge N onward; when rd_en=0, outputs SHALL hold.
REQ-022 SHALL bypass: a read in the same cycle as a write to the same thread and index (index!=0) SHALL return wb_data; rs1 and rs2 SHALL bypass independently.
REQ-023 SHALL keep a pending bit per thread/register; set at the edge when issue_valid=1 and issue_rd!=0 for [issue_thread][issue_rd].
REQ-024 SHALL clear pending[wb_thread_index][wb_reg_index] at the edge when wb_flag=1.
REQ-025 SHALL, on simultaneous set and clear of the same entry, leave it set (the newer issue wins).
REQ-026 SHALL never set the pending bit for register 0.
REQ-027 SHALL drive hazard = rd_en AND (P(rs1_index) OR P(rs2_index)), where P(r) = pending[rd_thread][r] AND NOT (wb_flag AND wb_thread_index=rd_thread AND wb_reg_index=r), since the bypass covers the completing write.
REQ-028 SHALL drive thread_idle[t] from the registered pending state: high iff all 32 pending bits of thread t are 0.
REQ-029 SHALL not gate reads on hazard; the consumer stalls externally and re-asserts rd_en.

Reset
REQ-030 SHALL, while reset=1 at an edge, clear all pending bits, drive rs1_data=0, rs2_data=0 and thread_idle all ones, and ignore wb_flag and issue_valid.
REQ-031 SHALL leave register storage contents unchanged by reset; contents are undefined until first written (register 0 excepted).
REQ-032 SHALL, after reset deasserts mid-operation, resume with no pending hazards; write-backs arriving then clear nothing and raise no error.

Verification
REQ-033 SHALL pass: write thread 2, r5=64'hDEAD_BEEF; next cycle rd_en, rd_thread=2, rs1=5 -> rs1_data=64'hDEAD_BEEF one cycle later; thread 3 r5 unaffected.
REQ-034 SHALL pass: same-cycle wb (thread 1, r7=64'h1234) and read (thread 1, rs1=7, rs2=7) -> both outputs 64'h1234 next cycle.
REQ-035 SHALL pass: write r0=64'hFFFF, issue_rd=0 -> rs1=0 reads 0, hazard=0, thread_idle unchanged.
REQ-036 SHALL pass: issue thread 4 r9; next cycle read rs2=9 thread 4 -> hazard=1, thread_idle[4]=0; wb thread 4 r9 -> hazard=0 that cycle, thread_idle[4]=1 next cycle.
REQ-037 SHALL pass: issue and wb to thread 0 r3 in the same cycle -> pending stays set, hazard=1 on next read of r3.
REQ-038 SHALL pass: 3 pending regs, reset for 1 cycle -> thread_idle=8'hFF, hazard=0, rs1_data=rs2_data=0.
